// File: rtl/fp_pkg.sv
// fp_pkg - shared definitions for the floating-point multiplier slice.
//   * flag bit positions within the 4-bit exception vector
//   * operand class encoding produced by fp_unpack
//   * constant-pattern helpers (bias, +inf, canonical qNaN) for any
//     EXP_W/MAN_W; results are returned in a 64-bit container and
//     narrowed by the caller with a size cast.
package fp_pkg;

    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    localparam int unsigned FP_MAX_W = 64;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    // 2^(exp_w-1) - 1
    function automatic logic [FP_MAX_W-1:0] fp_bias(input int unsigned exp_w);
        return (FP_MAX_W'(1) << (exp_w - 1)) - FP_MAX_W'(1);
    endfunction

    // Positive infinity: exponent all ones, mantissa zero, sign zero.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input int unsigned exp_w,
                                                   input int unsigned man_w);
        return ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
    endfunction

    // Canonical quiet NaN: +inf pattern with the mantissa MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                    input int unsigned man_w);
        return fp_inf(exp_w, man_w) | (FP_MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack - combinational operand classifier.
//   op_i    : packed operand {sign, exponent, mantissa}
//   sign_o  : sign bit
//   exp_o   : biased exponent field
//   cls_o   : ZERO (exp==0, subnormals flushed), INF, NAN or NORM
//   sig_o   : significand with hidden bit for NORM, zero otherwise
module fp_unpack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output fp_class_e            cls_o,
    output logic [MAN_W:0]       sig_o
);

    logic [MAN_W-1:0] man;

    assign sign_o = op_i[EXP_W+MAN_W];
    assign exp_o  = op_i[MAN_W +: EXP_W];
    assign man    = op_i[MAN_W-1:0];

    always_comb begin
        cls_o = NORM;
        sig_o = {1'b1, man};
        if (exp_o == '0) begin
            cls_o = ZERO;
            sig_o = '0;
        end else if (exp_o == '1) begin
            cls_o = (man == '0) ? INF : NAN;
            sig_o = '0;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe - 3-stage pipelined floating-point multiplier, RNE rounding,
// subnormals treated as zero on input and flushed to zero on output.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake
//   a, b              : operands {sign, exponent, mantissa}
//   out_valid/out_ready : result handshake
//   res               : product
//   flags             : {invalid, overflow, underflow, inexact}, aligned with res
// The pipeline uses a single global stall: every stage advances when the
// output register is empty or being drained.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic [3:0]           flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned XW = EXP_W + 2;

    localparam logic [W-1:0]         INF_PAT  = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-1:0]         QNAN_PAT = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0] BIAS_X   = XW'(fp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX  = signed'({2'b00, {EXP_W{1'b1}}});
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    logic advance;

    // ---------------- stage 1: unpack / multiply ----------------
    logic             sgn_a, sgn_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    fp_class_e        cls_a, cls_b;
    logic [MAN_W:0]   sig_a, sig_b;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op_i   (a),
        .sign_o (sgn_a),
        .exp_o  (exp_a),
        .cls_o  (cls_a),
        .sig_o  (sig_a)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op_i   (b),
        .sign_o (sgn_b),
        .exp_o  (exp_b),
        .cls_o  (cls_b),
        .sig_o  (sig_b)
    );

    logic                 s1_valid_q;
    logic                 s1_sign_q,    s1_sign_d;
    logic [PW-1:0]        s1_prod_q,    s1_prod_d;
    logic signed [XW-1:0] s1_exp_q,     s1_exp_d;
    logic                 s1_invalid_q, s1_invalid_d;
    logic                 s1_inf_q,     s1_inf_d;
    logic                 s1_zero_q,    s1_zero_d;

    always_comb begin
        logic any_nan;
        any_nan      = (cls_a == NAN) | (cls_b == NAN);
        s1_inf_d     = (cls_a == INF) | (cls_b == INF);
        s1_zero_d    = (cls_a == ZERO) | (cls_b == ZERO);
        s1_invalid_d = any_nan | (s1_inf_d & s1_zero_d);
        s1_sign_d    = sgn_a ^ sgn_b;
        s1_prod_d    = PW'(sig_a) * PW'(sig_b);
        s1_exp_d     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;
    end

    // ---------------- stage 2: normalise / round ----------------
    logic                 s2_valid_q;
    logic                 s2_sign_q;
    logic                 s2_invalid_q;
    logic                 s2_inf_q;
    logic                 s2_zero_q;
    logic signed [XW-1:0] s2_exp_q,     s2_exp_d;
    logic [MAN_W-1:0]     s2_man_q,     s2_man_d;
    logic                 s2_inexact_q, s2_inexact_d;

    // Only the stored fraction is carried through rounding; the hidden bit
    // is implicit, so a carry out of the fraction is the renormalise case.
    always_comb begin
        logic [MAN_W-1:0]     frac;
        logic                 guard;
        logic                 sticky;
        logic                 inc;
        logic                 carry;
        logic [MAN_W-1:0]     frac_r;
        logic signed [XW-1:0] exp_n;

        if (s1_prod_q[PW-1]) begin
            frac   = s1_prod_q[PW-2 -: MAN_W];
            guard  = s1_prod_q[MAN_W];
            sticky = |s1_prod_q[MAN_W-1:0];
            exp_n  = s1_exp_q + XW'(1);
        end else begin
            frac   = s1_prod_q[PW-3 -: MAN_W];
            guard  = s1_prod_q[MAN_W-1];
            sticky = |s1_prod_q[MAN_W-2:0];
            exp_n  = s1_exp_q;
        end

        inc             = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(inc);

        s2_man_d     = frac_r;
        s2_exp_d     = carry ? exp_n + XW'(1) : exp_n;
        s2_inexact_d = guard | sticky;
    end

    // ---------------- stage 3: pack / exceptions ----------------
    logic         out_valid_q;
    logic [W-1:0] res_q,   res_d;
    logic [3:0]   flags_q, flags_d;

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        if (s2_invalid_q) begin
            res_d                 = QNAN_PAT;
            flags_d[FLAG_INVALID] = 1'b1;
        end else if (s2_inf_q) begin
            res_d = {s2_sign_q, INF_PAT[W-2:0]};
        end else if (s2_zero_q) begin
            res_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (s2_exp_q >= EXP_MAX) begin
            res_d                  = {s2_sign_q, INF_PAT[W-2:0]};
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (s2_exp_q <= EXP_ZERO) begin
            res_d                   = {s2_sign_q, {(W-1){1'b0}}};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
            res_d                 = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
            flags_d[FLAG_INEXACT] = s2_inexact_q;
        end
    end

    // ---------------- pipeline control ----------------
    assign advance   = out_ready | ~out_valid_q;
    assign in_ready  = advance | rst;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by
    // the stage valid bits.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign_q    <= s1_sign_d;
            s1_prod_q    <= s1_prod_d;
            s1_exp_q     <= s1_exp_d;
            s1_invalid_q <= s1_invalid_d;
            s1_inf_q     <= s1_inf_d;
            s1_zero_q    <= s1_zero_d;

            s2_sign_q    <= s1_sign_q;
            s2_invalid_q <= s1_invalid_q;
            s2_inf_q     <= s1_inf_q;
            s2_zero_q    <= s1_zero_q;
            s2_exp_q     <= s2_exp_d;
            s2_man_q     <= s2_man_d;
            s2_inexact_q <= s2_inexact_d;
        end
    end

endmodule
